// File: rtl/cpu_pkg.sv
// Shared CPU constants: ALU operation encodings and the link register index.
package cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT on two's complement operands, wrapping, no overflow flag.
module alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opc,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  logic slt;

  assign slt = ($signed(a) < $signed(b));

  always_comb begin
    result = '0;
    case (opc)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt};
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, destination select and the EX/MEM register.
// One cycle from ID/EX values to outputs; stall holds EX/MEM, flush (which wins) loads a bubble.
module ex_stage
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic [WIDTH-1:0]    rega_data,
  input  logic [WIDTH-1:0]    regb_data,
  input  logic [WIDTH-1:0]    pc1,
  input  logic [WIDTH-1:0]    data_extend16,
  input  logic [REG_BITS-1:0] rs,
  input  logic [REG_BITS-1:0] rt,
  input  logic [REG_BITS-1:0] rd,
  input  logic [2:0]          alu_opc,
  input  logic                reg_dst,
  input  logic                r31,
  input  logic                reg_write,
  input  logic                alu_src,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                mem_to_reg,
  input  logic                write_pc_4,
  input  logic                wb_reg_write,
  input  logic [REG_BITS-1:0] wb_write_reg,
  input  logic [WIDTH-1:0]    wb_write_data,
  output logic [WIDTH-1:0]    alu_result_o,
  output logic                zero_o,
  output logic [WIDTH-1:0]    store_data_o,
  output logic [WIDTH-1:0]    pc1_o,
  output logic [REG_BITS-1:0] write_reg_o,
  output logic                reg_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                mem_to_reg_o,
  output logic                write_pc_4_o
);

  logic [WIDTH-1:0]    alu_result_q, store_data_q, pc1_q;
  logic [REG_BITS-1:0] write_reg_q;
  logic                zero_q, reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q, write_pc_4_q;

  logic [WIDTH-1:0]    alu_result_d, store_data_d, alu_b;
  logic [REG_BITS-1:0] write_reg_d;
  logic                zero_d;

  logic [WIDTH-1:0]    exmem_fwd, op_a, op_b;
  logic                ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;

  // Loads in EX/MEM are never forwarded: the ID hazard unit already bubbled the consumer.
  assign exmem_fwd = write_pc_4_q ? pc1_q : alu_result_q;

  assign ex_hit_a = reg_write_q && !mem_to_reg_q && (write_reg_q == rs) && (rs != '0);
  assign ex_hit_b = reg_write_q && !mem_to_reg_q && (write_reg_q == rt) && (rt != '0);
  assign wb_hit_a = wb_reg_write && (wb_write_reg == rs) && (rs != '0);
  assign wb_hit_b = wb_reg_write && (wb_write_reg == rt) && (rt != '0);

  assign op_a = ex_hit_a ? exmem_fwd : (wb_hit_a ? wb_write_data : rega_data);
  assign op_b = ex_hit_b ? exmem_fwd : (wb_hit_b ? wb_write_data : regb_data);

  assign alu_b        = alu_src ? data_extend16 : op_b;
  assign store_data_d = op_b;
  assign write_reg_d  = r31 ? REG_BITS'(REG_RA) : (reg_dst ? rd : rt);

  alu #(.WIDTH(WIDTH)) u_alu (
    .a      (op_a),
    .b      (alu_b),
    .opc    (alu_opc),
    .result (alu_result_d),
    .zero   (zero_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      alu_result_q <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      pc1_q        <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_pc_4_q <= 1'b0;
    end else if (!stall) begin
      alu_result_q <= alu_result_d;
      zero_q       <= zero_d;
      store_data_q <= store_data_d;
      pc1_q        <= pc1;
      write_reg_q  <= write_reg_d;
      reg_write_q  <= reg_write;
      mem_read_q   <= mem_read;
      mem_write_q  <= mem_write;
      mem_to_reg_q <= mem_to_reg;
      write_pc_4_q <= write_pc_4;
    end
  end

  assign alu_result_o = alu_result_q;
  assign zero_o       = zero_q;
  assign store_data_o = store_data_q;
  assign pc1_o        = pc1_q;
  assign write_reg_o  = write_reg_q;
  assign reg_write_o  = reg_write_q;
  assign mem_read_o   = mem_read_q;
  assign mem_write_o  = mem_write_q;
  assign mem_to_reg_o = mem_to_reg_q;
  assign write_pc_4_o = write_pc_4_q;

endmodule
